// File: rtl/transmissor_16.sv
// Serial transmitter for a 16-bit word sent as two parity-protected UART frames,
// low byte first, with back-to-back frames and fully registered outputs.
module transmissor_16 #(
   parameter int M              = 5208,
   parameter bit PARIDADE_IMPAR = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        partida,
   input  logic [15:0] dados,
   output logic        saida_serial,
   output logic        ocupado,
   output logic        pronto,
   output logic [2:0]  db_estado
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TX_B0 = 3'd1,
      TX_B1 = 3'd2,
      DONE  = 3'd3
   } state_t;

   localparam int             TW       = $clog2(M);
   localparam logic [TW-1:0]  TICK_MAX = TW'(M - 1);

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [4:0]    bit_q, bit_d;
   logic [20:0]   shift_q, shift_d;
   logic          saida_q, saida_d;
   logic          pronto_q, pronto_d;
   logic          ocupado_q, ocupado_d;
   logic [2:0]    db_q, db_d;
   logic          wrap;

   // Frame without its start bit, LSB first: data, parity, stop.
   function automatic logic [9:0] frame_body(input logic [7:0] b);
      frame_body = {1'b1, (^b) ^ PARIDADE_IMPAR, b};
   endfunction

   assign wrap = (tick_q == TICK_MAX);

   // The shift register holds the bits still to be sent after the current one.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      saida_d   = saida_q;
      pronto_d  = 1'b0;
      case (state_q)
         IDLE: begin
            saida_d = 1'b1;
            if (partida) begin
               state_d = TX_B0;
               shift_d = {frame_body(dados[15:8]), 1'b0, frame_body(dados[7:0])};
               saida_d = 1'b0;
               tick_d  = '0;
               bit_d   = 5'd0;
            end
         end
         TX_B0, TX_B1: begin
            if (wrap) begin
               tick_d = '0;
               if (bit_q == 5'd21) begin
                  state_d  = DONE;
                  saida_d  = 1'b1;
                  pronto_d = 1'b1;
                  bit_d    = 5'd0;
                  shift_d  = '0;
               end else begin
                  bit_d   = bit_q + 5'd1;
                  saida_d = shift_q[0];
                  shift_d = {1'b1, shift_q[20:1]};
                  if (bit_q == 5'd10) begin
                     state_d = TX_B1;
                  end
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            saida_d = 1'b1;
            tick_d  = '0;
            bit_d   = 5'd0;
         end
         default: begin
            state_d = IDLE;
            saida_d = 1'b1;
            tick_d  = '0;
            bit_d   = 5'd0;
            shift_d = '0;
         end
      endcase
      ocupado_d = (state_d != IDLE);
      db_d      = state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= 5'd0;
         shift_q   <= '0;
         saida_q   <= 1'b1;
         pronto_q  <= 1'b0;
         ocupado_q <= 1'b0;
         db_q      <= 3'd0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         saida_q   <= saida_d;
         pronto_q  <= pronto_d;
         ocupado_q <= ocupado_d;
         db_q      <= db_d;
      end
   end

   assign saida_serial = saida_q;
   assign pronto       = pronto_q;
   assign ocupado      = ocupado_q;
   assign db_estado    = db_q;

endmodule

// File: tb/tb_transmissor_16.sv
// Scoreboard bench for transmissor_16: an even- and an odd-parity instance share
// stimulus; a monitor compares every line sample against a frame-level model.
module tb_transmissor_16;

   localparam int M = 4;
   localparam int WORD_CYC = 22 * M;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        partida = 1'b0;
   logic [15:0] dados = 16'h0000;

   logic        line_e, ocup_e, pronto_e;
   logic [2:0]  db_e;
   logic        line_o, ocup_o, pronto_o;
   logic [2:0]  db_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   bit          active[2];
   int          idx[2];
   logic [15:0] cur_word[2];
   int          starts[2];
   int          dones[2];
   int          idle_gap[2];
   int          last_gap[2];

   transmissor_16 #(.M(M), .PARIDADE_IMPAR(1'b0)) u_even (
      .clock(clock), .reset(reset), .partida(partida), .dados(dados),
      .saida_serial(line_e), .ocupado(ocup_e), .pronto(pronto_e), .db_estado(db_e)
   );

   transmissor_16 #(.M(M), .PARIDADE_IMPAR(1'b1)) u_odd (
      .clock(clock), .reset(reset), .partida(partida), .dados(dados),
      .saida_serial(line_o), .ocupado(ocup_o), .pronto(pronto_o), .db_estado(db_o)
   );

   always #5 clock = ~clock;

   // Reference: the n-th serial bit (0..21) of a word, from the frame rules.
   function automatic logic model_bit(input logic [15:0] w, input bit odd, input int n);
      logic [7:0] b;
      int         j;
      b = (n < 11) ? w[7:0] : w[15:8];
      j = n % 11;
      if (j == 0)       model_bit = 1'b0;
      else if (j <= 8)  model_bit = b[j-1];
      else if (j == 9)  model_bit = (($countones(b) % 2) == 1) ^ odd;
      else              model_bit = 1'b1;
   endfunction

   task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   // Per-cycle monitor for one instance; starts a word when the idle line drops.
   task automatic monitorStep(input int inst, input logic line, input logic ocup, input logic pr, input logic [2:0] db);
      if (reset) begin
         active[inst] = 1'b0;
         idle_gap[inst] = 0;
         return;
      end
      if (!active[inst]) begin
         if (line === 1'b0) begin
            checkOutput("word_expected", inst, (inst == 0) ? q0.size() : q1.size(), (inst == 0) ? ((q0.size() > 0) ? q0.size() : 1) : ((q1.size() > 0) ? q1.size() : 1));
            if (inst == 0 && q0.size() > 0) cur_word[inst] = q0.pop_front();
            else if (inst == 1 && q1.size() > 0) cur_word[inst] = q1.pop_front();
            else cur_word[inst] = 16'h0000;
            active[inst] = 1'b1;
            idx[inst] = 0;
            starts[inst]++;
            last_gap[inst] = idle_gap[inst];
         end else begin
            checkOutput("idle_pronto", inst, pr, 1'b0);
            checkOutput("idle_ocupado", inst, ocup, 1'b0);
            checkOutput("idle_db", inst, db, 3'd0);
            idle_gap[inst]++;
            return;
         end
      end
      if (idx[inst] < WORD_CYC) begin
         checkOutput("line_bit", inst, line, model_bit(cur_word[inst], inst == 1, idx[inst] / M));
         checkOutput("busy_ocupado", inst, ocup, 1'b1);
         checkOutput("busy_pronto", inst, pr, 1'b0);
         checkOutput("busy_db", inst, db, (idx[inst] < 11 * M) ? 3'd1 : 3'd2);
      end else if (idx[inst] == WORD_CYC) begin
         checkOutput("done_line", inst, line, 1'b1);
         checkOutput("done_pronto", inst, pr, 1'b1);
         checkOutput("done_ocupado", inst, ocup, 1'b1);
         checkOutput("done_db", inst, db, 3'd3);
         dones[inst]++;
      end else begin
         checkOutput("after_line", inst, line, 1'b1);
         checkOutput("after_pronto", inst, pr, 1'b0);
         checkOutput("after_ocupado", inst, ocup, 1'b0);
         checkOutput("after_db", inst, db, 3'd0);
         active[inst] = 1'b0;
         idle_gap[inst] = 0;
      end
      idx[inst]++;
   endtask

   always @(negedge clock) begin
      monitorStep(0, line_e, ocup_e, pronto_e, db_e);
      monitorStep(1, line_o, ocup_o, pronto_o, db_o);
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic waitIdle();
      bit timed_out;
      timed_out = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!ocup_e && !ocup_o) begin
            timed_out = 1'b0;
            break;
         end
      end
      checkOutput("idle_timeout", 0, timed_out, 1'b0);
   endtask

   task automatic applyStimulus(input logic [15:0] w);
      waitIdle();
      dados = w;
      partida = 1'b1;
      q0.push_back(w);
      q1.push_back(w);
      tick();
      partida = 1'b0;
   endtask

   initial begin
      int d0, s0;
      bit timed_out;

      repeat (3) tick();
      checkOutput("reset_line", 0, line_e, 1'b1);
      checkOutput("reset_ocupado", 0, ocup_e, 1'b0);
      checkOutput("reset_pronto", 0, pronto_e, 1'b0);
      checkOutput("reset_db", 0, db_e, 3'd0);
      reset = 1'b0;
      repeat (3) tick();

      d0 = dones[0];
      applyStimulus(16'h1234);
      applyStimulus(16'hFFFF);
      applyStimulus(16'h0000);
      for (int i = 0; i < 6; i++) applyStimulus(16'($urandom));
      waitIdle();
      checkOutput("pronto_count", 0, dones[0] - d0, 9);

      // partida and dados toggled mid-word and again during DONE are ignored
      d0 = dones[0];
      applyStimulus(16'hBEEF);
      repeat (8) tick();
      partida = 1'b1;
      dados = 16'h0000;
      repeat (4) tick();
      partida = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (pronto_e) begin
            timed_out = 1'b0;
            break;
         end
      end
      checkOutput("done_wait_timeout", 0, timed_out, 1'b0);
      partida = 1'b1;
      tick();
      partida = 1'b0;
      repeat (40) tick();
      waitIdle();
      checkOutput("ignore_pronto_count", 0, dones[0] - d0, 1);

      // asynchronous reset in the middle of the high byte
      applyStimulus(16'h5A5A);
      repeat (11 * M + 10) tick();
      reset = 1'b1;
      #1;
      checkOutput("async_line_e", 0, line_e, 1'b1);
      checkOutput("async_ocupado_e", 0, ocup_e, 1'b0);
      checkOutput("async_db_e", 0, db_e, 3'd0);
      checkOutput("async_line_o", 1, line_o, 1'b1);
      checkOutput("async_ocupado_o", 1, ocup_o, 1'b0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();
      d0 = dones[0];
      applyStimulus(16'hA5C3);
      waitIdle();
      checkOutput("post_reset_pronto", 0, dones[0] - d0, 1);

      // partida held high: two words with exactly DONE+IDLE high between them
      waitIdle();
      d0 = dones[0];
      s0 = starts[0];
      dados = 16'h3C96;
      q0.push_back(16'h3C96);
      q0.push_back(16'h3C96);
      q1.push_back(16'h3C96);
      q1.push_back(16'h3C96);
      partida = 1'b1;
      timed_out = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (starts[0] >= s0 + 2) begin
            timed_out = 1'b0;
            break;
         end
      end
      partida = 1'b0;
      checkOutput("b2b_start_timeout", 0, timed_out, 1'b0);
      checkOutput("b2b_gap", 0, last_gap[0], 0);
      checkOutput("b2b_gap_odd", 1, last_gap[1], 0);
      waitIdle();
      repeat (5) tick();
      checkOutput("b2b_pronto_count", 0, dones[0] - d0, 2);

      repeat (20) tick();
      checkOutput("queue_empty_e", 0, q0.size(), 0);
      checkOutput("queue_empty_o", 1, q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
